// File: rtl/ppm_frame_ctrl.sv
// rtl/ppm_frame_ctrl.sv - frame scheduler feeding the 4-PPM symbol modulator
module ppm_frame_ctrl #(
  parameter int         PREAMBLE_SYMS    = 8,
  parameter logic [7:0] SYNC_BYTE        = 8'hD5,
  parameter int         GUARD_CYCLES     = 32,
  parameter int         UNDERRUN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] sym_code,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int CW = (PREAMBLE_SYMS > 4) ? $clog2(PREAMBLE_SYMS) : 2;
  localparam int SW = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0] PRE_LAST    = CW'(PREAMBLE_SYMS - 1);
  localparam logic [CW-1:0] SYM_LAST    = CW'(3);
  localparam logic [SW-1:0] STARVE_LAST = SW'(UNDERRUN_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SYNC, S_HEADER, S_PAYLOAD, S_GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sym_code_q, sym_code_d;
  logic          sym_valid_q, sym_valid_d;
  logic          data_ready_q, data_ready_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;
  logic          aborted_q, aborted_d;
  logic          idle_hold_q, idle_hold_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    bytes_left_q, bytes_left_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [GW-1:0] guard_q, guard_d;

  logic          sym_acc;
  logic [CW-1:0] cnt_inc;

  assign sym_acc = sym_valid_q && sym_ready;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    sym_code_d   = sym_code_q;
    sym_valid_d  = sym_valid_q;
    data_ready_d = data_ready_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    aborted_d    = aborted_q;
    idle_hold_d  = 1'b0;
    len_d        = len_q;
    bytes_left_d = bytes_left_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    guard_d      = guard_q;

    // Mid-byte symbols are shared by SYNC, HEADER and PAYLOAD.
    if (sym_acc && (state_q inside {S_SYNC, S_HEADER, S_PAYLOAD}) && (cnt_q != SYM_LAST)) begin
      sym_code_d = shreg_q[7:6];
      shreg_d    = {shreg_q[5:0], 2'b00};
      cnt_d      = cnt_inc;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start && !idle_hold_q) begin
          state_d     = S_PREAMBLE;
          len_d       = tx_len;
          cnt_d       = '0;
          sym_valid_d = 1'b1;
          sym_code_d  = 2'b00;
          aborted_d   = 1'b0;
        end
      end
      S_PREAMBLE: begin
        if (sym_acc) begin
          if (cnt_q == PRE_LAST) begin
            state_d    = S_SYNC;
            sym_code_d = SYNC_BYTE[7:6];
            shreg_d    = {SYNC_BYTE[5:0], 2'b00};
            cnt_d      = '0;
          end else begin
            cnt_d      = cnt_inc;
            sym_code_d = cnt_inc[0] ? 2'b11 : 2'b00;
          end
        end
      end
      S_SYNC: begin
        if (sym_acc && cnt_q == SYM_LAST) begin
          state_d    = S_HEADER;
          sym_code_d = len_q[7:6];
          shreg_d    = {len_q[5:0], 2'b00};
          cnt_d      = '0;
        end
      end
      S_HEADER: begin
        if (sym_acc && cnt_q == SYM_LAST) begin
          sym_valid_d = 1'b0;
          if (len_q == 8'd0) begin
            state_d = S_GUARD;
            guard_d = '0;
          end else begin
            state_d      = S_PAYLOAD;
            bytes_left_d = len_q;
            data_ready_d = 1'b1;
            starve_d     = '0;
          end
        end
      end
      S_PAYLOAD: begin
        // data_ready and sym_valid are never high together here.
        if (data_ready_q) begin
          if (data_valid) begin
            data_ready_d = 1'b0;
            sym_valid_d  = 1'b1;
            sym_code_d   = data[7:6];
            shreg_d      = {data[5:0], 2'b00};
            cnt_d        = '0;
            bytes_left_d = bytes_left_q - 8'd1;
            starve_d     = '0;
          end else if (starve_q == STARVE_LAST) begin
            data_ready_d = 1'b0;
            underrun_d   = 1'b1;
            aborted_d    = 1'b1;
            state_d      = S_GUARD;
            guard_d      = '0;
            starve_d     = '0;
          end else begin
            starve_d = starve_q + SW'(1);
          end
        end else if (sym_acc && cnt_q == SYM_LAST) begin
          sym_valid_d = 1'b0;
          if (bytes_left_q == 8'd0) begin
            state_d = S_GUARD;
            guard_d = '0;
          end else begin
            data_ready_d = 1'b1;
          end
        end
      end
      S_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          state_d      = S_IDLE;
          frame_done_d = !aborted_q;
          idle_hold_d  = 1'b1;
          guard_d      = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sym_code_q   <= 2'b00;
      sym_valid_q  <= 1'b0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      aborted_q    <= 1'b0;
      idle_hold_q  <= 1'b0;
      len_q        <= '0;
      bytes_left_q <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      guard_q      <= '0;
    end else begin
      state_q      <= state_d;
      sym_code_q   <= sym_code_d;
      sym_valid_q  <= sym_valid_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      aborted_q    <= aborted_d;
      idle_hold_q  <= idle_hold_d;
      len_q        <= len_d;
      bytes_left_q <= bytes_left_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      guard_q      <= guard_d;
    end
  end

  assign sym_code   = sym_code_q;
  assign sym_valid  = sym_valid_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// tb/tb_ppm_frame_ctrl.sv - scoreboard bench for ppm_frame_ctrl
module tb_ppm_frame_ctrl;
  localparam int GUARD = 32;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst, tx_start;
  logic [7:0] tx_len, data;
  logic       data_valid, data_ready;
  logic [1:0] sym_code;
  logic       sym_valid, sym_ready, busy, frame_done, underrun;

  always #5 clk = ~clk;

  ppm_frame_ctrl dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .sym_code(sym_code), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, last_acc = 0, starve = 0, und_cyc = 0, dr_cnt = 0;
  int rdy_mode = 0, rdy_cnt = 0;
  bit und_pend = 0, stall_pend = 0;
  logic [1:0] stall_code;
  logic [1:0] exp_sym[$];
  int         exp_evt[$];
  logic [7:0] data_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted symbol and status pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_pend = 0;
        starve     = 0;
        und_pend   = 0;
      end else begin
        if (stall_pend) begin
          check("hold_valid", int'(sym_valid), 1);
          check("hold_code", int'(sym_code), int'(stall_code));
        end
        stall_pend = sym_valid && !sym_ready;
        stall_code = sym_code;
        if (sym_valid && sym_ready) begin
          if (exp_sym.size() == 0) check("sym_unexpected", 1, 0);
          else check("sym_code", int'(sym_code), int'(exp_sym.pop_front()));
          last_acc = cyc;
          n_acc++;
        end
        if (data_ready) dr_cnt++;
        if (frame_done) begin
          if (exp_evt.size() == 0) check("evt_unexpected_done", 1, 0);
          else check("evt_kind_done", exp_evt.pop_front(), 1);
          check("done_guard_len", cyc - last_acc, GUARD + 1);
          check("done_busy", int'(busy), 0);
        end
        if (underrun) begin
          if (exp_evt.size() == 0) check("evt_unexpected_underrun", 1, 0);
          else check("evt_kind_underrun", exp_evt.pop_front(), 2);
          check("underrun_starve_len", starve, TMO);
          und_cyc  = cyc;
          und_pend = 1;
        end
        if (und_pend && !busy) begin
          check("underrun_guard_len", cyc - und_cyc, GUARD);
          und_pend = 0;
        end
        if (data_ready && !data_valid) starve++;
        else starve = 0;
      end
    end
  end

  initial begin
    data_valid = 1'b0;
    data = 8'h00;
    forever begin
      @(negedge clk);
      if (data_valid && data_ready && !rst && data_q.size() > 0) void'(data_q.pop_front());
      @(posedge clk);
      #1;
      data_valid = (data_q.size() > 0);
      data = data_valid ? data_q[0] : 8'h00;
    end
  end

  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cnt++;
      case (rdy_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = ((rdy_cnt / 3) % 2) == 0;
        default: sym_ready = 1'b0;
      endcase
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) exp_sym.push_back(b[2*i +: 2]);
  endtask

  task automatic push_hdr(input logic [7:0] len);
    for (int i = 0; i < 8; i++) exp_sym.push_back((i % 2) ? 2'b11 : 2'b00);
    push_byte(8'hD5);
    push_byte(len);
  endtask

  task automatic start_frame(input logic [7:0] len);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_len   = len;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || exp_sym.size() != 0 || exp_evt.size() != 0) && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_timeout"}, int'(k < 4000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_sym_valid"}, int'(sym_valid), 0);
    check({name, "_sym_code"}, int'(sym_code), 0);
    check({name, "_data_ready"}, int'(data_ready), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_frame_done"}, int'(frame_done), 0);
    check({name, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    int k;
    int n0;
    rst = 1'b1;
    tx_start = 1'b0;
    tx_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: two-byte frame, sym_ready always high
    dr_cnt = 0;
    push_hdr(8'd2); push_byte(8'h1B); push_byte(8'hE4);
    data_q.push_back(8'h1B); data_q.push_back(8'hE4);
    exp_evt.push_back(1);
    start_frame(8'd2);
    wait_idle("s1");
    check("s1_data_ready_cycles", dr_cnt, 2);

    // 2: header-only frame
    dr_cnt = 0;
    push_hdr(8'd0);
    exp_evt.push_back(1);
    start_frame(8'd0);
    wait_idle("s2");
    check("s2_data_ready_never", dr_cnt, 0);

    // 3: sym_ready toggling every 3 cycles
    rdy_mode = 1;
    push_hdr(8'd2); push_byte(8'h1B); push_byte(8'hE4);
    data_q.push_back(8'h1B); data_q.push_back(8'hE4);
    exp_evt.push_back(1);
    start_frame(8'd2);
    wait_idle("s3");
    rdy_mode = 0;

    // 4: starvation after the first of three bytes
    push_hdr(8'd3); push_byte(8'hA5);
    data_q.push_back(8'hA5);
    exp_evt.push_back(2);
    start_frame(8'd3);
    wait_idle("s4");
    check("s4_no_pending_underrun", int'(und_pend), 0);

    // 5: tx_start while busy and in the frame_done cycle is ignored
    push_hdr(8'd1); push_byte(8'h3C);
    data_q.push_back(8'h3C);
    exp_evt.push_back(1);
    start_frame(8'd1);
    repeat (5) @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_len = 8'd7;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    k = 0;
    while (!frame_done && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("s5_done_seen", int'(frame_done), 1);
    push_hdr(8'd1); push_byte(8'h96);
    data_q.push_back(8'h96);
    exp_evt.push_back(1);
    tx_start = 1'b1;
    tx_len = 8'd1;
    @(posedge clk);
    #1;
    check("s5_ignored_in_done_cycle", int'(busy), 0);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    check("s5_next_cycle_starts", int'(busy), 1);
    wait_idle("s5");

    // 6: reset mid-payload with a stalled symbol, then a fresh frame
    push_hdr(8'd2); push_byte(8'h1B); push_byte(8'hE4);
    data_q.push_back(8'h1B); data_q.push_back(8'hE4);
    exp_evt.push_back(1);
    n0 = n_acc;
    start_frame(8'd2);
    k = 0;
    while (n_acc < n0 + 18 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("s6_reach_payload", int'(k < 500), 1);
    rdy_mode = 2;
    sym_ready = 1'b0;
    @(posedge clk);
    #1;
    check("s6_pending_valid", int'(sym_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sym.delete();
    exp_evt.delete();
    data_q.delete();
    rdy_mode = 0;
    sym_ready = 1'b1;
    check_reset("s6_reset");
    repeat (2) @(posedge clk);
    #1;
    dr_cnt = 0;
    push_hdr(8'd2); push_byte(8'h1B); push_byte(8'hE4);
    data_q.push_back(8'h1B); data_q.push_back(8'hE4);
    exp_evt.push_back(1);
    start_frame(8'd2);
    wait_idle("s6_fresh");
    check("s6_data_ready_cycles", dr_cnt, 2);

    check("sb_sym_empty", exp_sym.size(), 0);
    check("sb_evt_empty", exp_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
